// File: rtl/output_pulse_gen.sv
// Pulse timeline generator: produces one pulse of configurable delay and width,
// spread over parallel words for a downstream output SERDES (bit 0 sent first).
//
// state | meaning
// IDLE  | no pulse pending; data_out at idle level
// DELAY | data_out carries a word lying entirely before the first pulse bit
// PULSE | data_out carries a word holding at least one pulse bit
module output_pulse_gen #(
  parameter int DATA_WIDTH   = 4,
  parameter int DELAY_WIDTH  = 24,
  parameter int PWIDTH_WIDTH = 16
) (
  input  logic                    clk_div_in,
  input  logic                    reset_n,
  input  logic                    trigger,
  input  logic [DELAY_WIDTH-1:0]  delay,
  input  logic [PWIDTH_WIDTH-1:0] pulse_width,
  input  logic                    invert,
  input  logic                    enable,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    busy,
  output logic                    trigger_dropped
);

  localparam int MW = (DELAY_WIDTH > PWIDTH_WIDTH) ? DELAY_WIDTH : PWIDTH_WIDTH;
  localparam int EW = MW + 1;
  // Bit-index/word width keeps headroom above the largest end index, so no wrap.
  localparam int KW = MW + 3;
  localparam logic [KW-1:0] DW_K = KW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          word_q, word_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [EW-1:0]          end_q, end_d;
  logic [DATA_WIDTH-1:0]  mask_q, mask_d;
  logic                   busy_q, busy_d;
  logic                   drop_q, drop_d;

  logic                   use_in;
  logic [EW-1:0]          end_in;
  logic [KW-1:0]          dl_sel, en_sel, w_sel, kbase, k;
  logic [DATA_WIDTH-1:0]  mask_calc;
  logic                   next_in_pulse, last_shown;

  always_comb begin
    use_in    = (state_q == IDLE);
    end_in    = EW'(delay) + EW'(pulse_width);
    dl_sel    = use_in ? KW'(delay) : KW'(delay_q);
    en_sel    = use_in ? KW'(end_in) : KW'(end_q);
    w_sel     = use_in ? '0 : word_q;
    kbase     = w_sel * DW_K;
    k         = '0;
    mask_calc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      k            = kbase + KW'(i);
      mask_calc[i] = (k >= dl_sel) && (k < en_sel);
    end
    next_in_pulse = (kbase + DW_K) > dl_sel;
    // word_q indexes the next word, so word_q*DW is one past the shown word.
    last_shown    = KW'(end_q) <= (word_q * DW_K);
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    delay_d = delay_q;
    end_d   = end_q;
    mask_d  = '0;
    busy_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && trigger && (pulse_width != '0)) begin
          delay_d = delay;
          end_d   = end_in;
          word_d  = KW'(1);
          mask_d  = mask_calc;
          busy_d  = 1'b1;
          state_d = next_in_pulse ? PULSE : DELAY;
        end
      end
      DELAY, PULSE: begin
        if (!enable) begin
          state_d = IDLE;
          word_d  = '0;
        end else begin
          drop_d = trigger;
          if (last_shown) begin
            state_d = IDLE;
            word_d  = '0;
          end else begin
            mask_d  = mask_calc;
            busy_d  = 1'b1;
            word_d  = word_q + KW'(1);
            state_d = next_in_pulse ? PULSE : DELAY;
          end
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
      end
    endcase
  end

  // reset_n deassertion is expected to be synchronised upstream to clk_div_in.
  always_ff @(posedge clk_div_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      delay_q <= '0;
      end_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      delay_q <= delay_d;
      end_q   <= end_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Polarity is applied after the register so idle level follows invert in reset too.
  assign data_out        = mask_q ^ {DATA_WIDTH{invert}};
  assign busy            = busy_q;
  assign trigger_dropped = drop_q;

endmodule

// File: doc/output_pulse_gen.md
OUTPUT_PULSE_GEN -- requirements
Module: output_pulse_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 4: serial bits per parallel word; legal range 2..8; bit 0 of each word is transmitted first.
REQ-002 Parameter DELAY_WIDTH, default 24: width of the delay field, in serial-bit units.
REQ-003 Parameter PWIDTH_WIDTH, default 16: width of the pulse-width field, in serial-bit units.
REQ-004 clk_div_in  input  1: parallel-side clock; the only clock in the block.
REQ-005 reset_n  input  1: asynchronous assert, synchronous deassert, active-low reset.
REQ-006 trigger  input  1: single-cycle start strobe.
REQ-007 delay  input  DELAY_WIDTH: serial bits from timeline bit 0 to the first pulse bit.
REQ-008 pulse_width  input  PWIDTH_WIDTH: pulse length in serial bits.
REQ-009 invert  input  1: output polarity; 1 inverts every output bit, including idle.
REQ-010 enable  input  1: block enable.
REQ-011 data_out  output  DATA_WIDTH: registered parallel word for the downstream output SERDES.
REQ-012 busy  output  1: registered; high while data_out carries a word inside the active window.
REQ-013 trigger_dropped  output  1: registered one-cycle flag for a rejected trigger.

Function
REQ-014 A trigger is accepted at a rising edge of clk_div_in when trigger=1, enable=1, and no pulse is pending.
REQ-015 On acceptance, delay and pulse_width SHALL be latched; later changes to these inputs SHALL NOT affect the pulse in progress.
REQ-016 Timeline definition:
- Accept cycle is T.
- Serial bit index k maps to data_out[k mod DATA_WIDTH] of the word output in cycle T+1+floor(k/DATA_WIDTH).
REQ-017 Bit k SHALL be active when delay <= k < delay+pulse_width; delay+pulse_width is computed at DELAY_WIDTH+1 bits, with no overflow.
REQ-018 Output bit levels:
- Active bit: data_out bit = ~invert.
- All other bits, including idle cycles: data_out bit = invert.
REQ-019 State machine has three states: IDLE, DELAY, PULSE.
- IDLE -> DELAY on acceptance when delay >= DATA_WIDTH.
- IDLE -> PULSE on acceptance otherwise.
- DELAY -> PULSE when the next output word contains bit index delay.
- PULSE -> IDLE after the word containing bit delay+pulse_width-1 has been output.
REQ-020 If pulse_width=0 on acceptance, the state SHALL stay IDLE, with no busy and no active bits, and no drop flag.
REQ-021 busy SHALL be 1 for every output word from T+1 through the word containing the last active bit, inclusive, and 0 otherwise.
REQ-022 Triggers while not in IDLE are ignored, and trigger_dropped SHALL be 1 in the following cycle.
REQ-023 A trigger while enable=0 is ignored and SHALL NOT set trigger_dropped.
REQ-024 Deasserting enable mid-pulse:
- Aborts the pulse: state -> IDLE at the next edge.
- data_out returns to idle level and busy to 0 from that edge.
REQ-025 A trigger coinciding with the cycle in which PULSE -> IDLE SHALL be dropped; there is no back-to-back acceptance in the same cycle.
REQ-026 Latency from trigger edge to the first word containing bit 0 SHALL be exactly one clk_div_in cycle.
REQ-027 The word counter SHALL be wide enough for ceil((2^DELAY_WIDTH + 2^PWIDTH_WIDTH)/DATA_WIDTH) words and SHALL never wrap during a pulse.

Reset
REQ-028 While reset_n=0:
- data_out = {DATA_WIDTH{invert}}, busy=0, trigger_dropped=0, state=IDLE.
- Latched fields and counters are cleared.
REQ-029 Assertion of reset_n mid-pulse SHALL return data_out to idle level asynchronously, without waiting for a clock edge.
REQ-030 After reset_n deasserts, the first trigger SHALL be acceptable at the first clk_div_in edge.

Verification (DATA_WIDTH=4, invert=0, enable=1 unless stated)
REQ-031 delay=5, pulse_width=3, trigger at T -> data_out 0000 at T+1, 1110 at T+2, 0000 at T+3; busy 1 at T+1..T+2.
REQ-032 delay=2, pulse_width=7 -> words 1100, 1111, 0001 at T+1..T+3; busy 1 for exactly 3 cycles.
REQ-033 delay=0, pulse_width=1, invert=1 -> 1110 at T+1, then 1111; busy 1 for one cycle.
REQ-034 pulse_width=0 -> data_out stays 0000, busy stays 0, trigger_dropped stays 0.
REQ-035 delay=8, pulse_width=4, second trigger at T+2 -> pulse 1111 at T+3 unchanged; trigger_dropped 1 at T+3 only.
REQ-036 delay=0, pulse_width=16, reset_n low at T+2 -> data_out 0000 and busy 0 immediately; a trigger after release yields a fresh pulse from bit 0.
